// File: rtl/reset_req_pkg.sv
// Shared encodings and default cycle constants
// for the reset request scheduler.
package reset_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_COOLDOWN = 2'd3
  } rr_state_e;

  localparam int unsigned RR_NUM_REQ         = 4;
  localparam int unsigned RR_PULSE_CYCLES    = 16;
  localparam int unsigned RR_COOLDOWN_CYCLES = 256;
  localparam int unsigned RR_TIMEOUT_CYCLES  = 65536;
  localparam int unsigned RR_CNT_W           = 32;

  function automatic int unsigned rr_idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_req_prio_enc.sv
// Lowest-set-bit priority encoder; index 0 wins.
// Returns 0 for an all-zero vector.
module reset_req_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/reset_req_sched.sv
// Reset request scheduler: merges request edges into one EXT_RESET pulse.
// Optional WAIT_REL timeout with sticky TIMEOUT_ERR: RESET_REQ_TIMEOUT_EN.
module reset_req_sched
  import reset_req_pkg::*;
#(
  parameter int unsigned NUM_REQ         = RR_NUM_REQ,
  parameter int unsigned PULSE_CYCLES    = RR_PULSE_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = RR_COOLDOWN_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = RR_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = RR_CNT_W
) (
  input  logic                         MAIN_CLK,
  input  logic                         MAIN_RESET_N,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ-1:0]           REQ_MASK,
  input  logic                         PERI_RESET_N,
  input  logic                         CLR_CAUSE,
  output logic                         EXT_RESET,
  output logic [NUM_REQ-1:0]           REQ_ACK,
  output logic [NUM_REQ-1:0]           CAUSE,
  output logic [rr_idx_w(NUM_REQ)-1:0] WINNER,
  output logic                         CAUSE_VALID,
`ifdef RESET_REQ_TIMEOUT_EN
  output logic                         TIMEOUT_ERR,
`endif
  output logic                         BUSY
);

  localparam int unsigned WIN_W = rr_idx_w(NUM_REQ);
  localparam int unsigned P_LAST =
    (PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1;
  localparam int unsigned C_LAST =
    (COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1;
  localparam bit C_ZERO = (COOLDOWN_CYCLES == 0);

  rr_state_e          state;
  rr_state_e          state_d;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] edge_v;
  logic               go_assert;
  logic               end_pulse;
  logic               tmo_hit;
  rr_state_e          rel_dst;

  assign edge_v  = REQ & ~req_q & ~REQ_MASK;
  assign rel_dst = C_ZERO ? ST_IDLE : ST_COOLDOWN;
  assign BUSY    = (state != ST_IDLE);

`ifdef RESET_REQ_TIMEOUT_EN
  localparam int unsigned T_LAST =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
`else
  logic unused_tmo;
  assign unused_tmo = |CNT_W'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
    if (!MAIN_RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    go_assert = 1'b0;
    end_pulse = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_d   = ST_ASSERT;
          go_assert = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt == CNT_W'(P_LAST)) begin
          state_d   = ST_WAIT_REL;
          end_pulse = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (PERI_RESET_N) begin
          state_d = rel_dst;
        end
`ifdef RESET_REQ_TIMEOUT_EN
        else if (cnt == CNT_W'(T_LAST)) begin
          state_d = rel_dst;
          tmo_hit = 1'b1;
        end
`endif
      end
      ST_COOLDOWN: begin
        if (cnt >= CNT_W'(C_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change.
  always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
    if (!MAIN_RESET_N) begin
      cnt <= '0;
    end else if (state_d != state) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
    if (!MAIN_RESET_N) begin
      req_q       <= '0;
      pending     <= '0;
      CAUSE       <= '0;
      CAUSE_VALID <= 1'b0;
      REQ_ACK     <= '0;
      EXT_RESET   <= 1'b0;
    end else begin
      req_q     <= REQ;
      EXT_RESET <= (state_d == ST_ASSERT);
      REQ_ACK   <= end_pulse ? (CAUSE | edge_v) : '0;
      if (go_assert) begin
        pending <= edge_v;
      end else if (state != ST_ASSERT) begin
        pending <= pending | edge_v;
      end
      if (go_assert) begin
        CAUSE <= pending;
      end else if (state == ST_ASSERT) begin
        CAUSE <= CAUSE | edge_v;
      end else if (CLR_CAUSE) begin
        CAUSE <= '0;
      end
      if (end_pulse) begin
        CAUSE_VALID <= 1'b1;
      end else if (CLR_CAUSE && state != ST_ASSERT) begin
        CAUSE_VALID <= 1'b0;
      end
    end
  end

`ifdef RESET_REQ_TIMEOUT_EN
  always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
    if (!MAIN_RESET_N) begin
      TIMEOUT_ERR <= 1'b0;
    end else if (tmo_hit) begin
      TIMEOUT_ERR <= 1'b1;
    end else if (CLR_CAUSE) begin
      TIMEOUT_ERR <= 1'b0;
    end
  end
`endif

  reset_req_prio_enc #(
    .N (NUM_REQ),
    .W (WIN_W)
  ) u_prio (
    .vec (CAUSE),
    .idx (WINNER)
  );

endmodule

// File: tb/tb_reset_req_sched.sv
// Directed bench for reset_req_sched.
// Build with RESET_REQ_TIMEOUT_EN to exercise the timeout path.
module tb_reset_req_sched;

  logic       MAIN_CLK = 1'b0;
  logic       MAIN_RESET_N;
  logic [3:0] REQ;
  logic [3:0] REQ_MASK;
  logic       PERI_RESET_N;
  logic       CLR_CAUSE;
  logic       EXT_RESET;
  logic [3:0] REQ_ACK;
  logic [3:0] CAUSE;
  logic [1:0] WINNER;
  logic       CAUSE_VALID;
  logic       BUSY;
`ifdef RESET_REQ_TIMEOUT_EN
  logic       TIMEOUT_ERR;
`endif

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] merge;
    logic       clr;
    logic [3:0] cause;
    logic [1:0] win;
  } vec_t;

  vec_t tbl [4];

  always #5 MAIN_CLK = ~MAIN_CLK;

  reset_req_sched #(
    .NUM_REQ         (4),
    .PULSE_CYCLES    (16),
    .COOLDOWN_CYCLES (256),
    .TIMEOUT_CYCLES  (100),
    .CNT_W           (32)
  ) dut (
    .MAIN_CLK     (MAIN_CLK),
    .MAIN_RESET_N (MAIN_RESET_N),
    .REQ          (REQ),
    .REQ_MASK     (REQ_MASK),
    .PERI_RESET_N (PERI_RESET_N),
    .CLR_CAUSE    (CLR_CAUSE),
    .EXT_RESET    (EXT_RESET),
    .REQ_ACK      (REQ_ACK),
    .CAUSE        (CAUSE),
    .WINNER       (WINNER),
    .CAUSE_VALID  (CAUSE_VALID),
`ifdef RESET_REQ_TIMEOUT_EN
    .TIMEOUT_ERR  (TIMEOUT_ERR),
`endif
    .BUSY         (BUSY)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge MAIN_CLK);
    #1;
  endtask

  task automatic wait_ext_low(input string name);
    int k = 0;
    while (EXT_RESET && k < 100) begin
      step(1);
      k++;
    end
    chk({name, " ext_low"}, EXT_RESET, 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (BUSY && k < 1000) begin
      step(1);
      k++;
    end
    chk({name, " idle"}, BUSY, 0);
  endtask

  task automatic clr_pulse();
    CLR_CAUSE = 1'b1;
    step(1);
    CLR_CAUSE = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    int n;
    t = $sformatf("v%0d", idx);
    REQ = v.req;
    step(1);
    chk({t, " lat1 ext"}, EXT_RESET, 0);
    chk({t, " lat1 busy"}, BUSY, 0);
    step(1);
    chk({t, " lat2 ext"}, EXT_RESET, 1);
    chk({t, " lat2 busy"}, BUSY, 1);
    n = 0;
    while (EXT_RESET && n < 100) begin
      n++;
      if (n == 3) REQ = v.req | v.merge;
      CLR_CAUSE = v.clr && (n == 5);
      step(1);
    end
    CLR_CAUSE = 1'b0;
    chk({t, " width"}, n, 16);
    chk({t, " ack"}, REQ_ACK, v.cause);
    chk({t, " cause"}, CAUSE, v.cause);
    chk({t, " winner"}, WINNER, v.win);
    chk({t, " valid"}, CAUSE_VALID, 1);
    step(1);
    chk({t, " ack_1cyc"}, REQ_ACK, 0);
    wait_idle(t);
    REQ = '0;
    step(1);
    clr_pulse();
    chk({t, " clr cause"}, CAUSE, 0);
    chk({t, " clr valid"}, CAUSE_VALID, 0);
    chk({t, " clr winner"}, WINNER, 0);
  endtask

  initial begin : main
    int i;
    int idle_at;
    tbl[0] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2};
    tbl[1] = '{4'b1010, 4'b0001, 1'b0, 4'b1011, 2'd0};
    tbl[2] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3};
    tbl[3] = '{4'b0010, 4'b1100, 1'b1, 4'b1110, 2'd1};

    MAIN_RESET_N = 1'b0;
    REQ          = '0;
    REQ_MASK     = '0;
    PERI_RESET_N = 1'b1;
    CLR_CAUSE    = 1'b0;
    step(3);
    chk("rst ext", EXT_RESET, 0);
    chk("rst ack", REQ_ACK, 0);
    chk("rst cause", CAUSE, 0);
    chk("rst winner", WINNER, 0);
    chk("rst valid", CAUSE_VALID, 0);
    chk("rst busy", BUSY, 0);
`ifdef RESET_REQ_TIMEOUT_EN
    chk("rst tmo", TIMEOUT_ERR, 0);
`endif
    MAIN_RESET_N = 1'b1;
    step(2);

    for (int k = 0; k < 4; k++) run_vec(k, tbl[k]);

    // Request arriving during cool-down waits for it.
    REQ = 4'b0100;
    step(2);
    wait_ext_low("cq first");
    step(1);
    i = 0;
    idle_at = -1;
    while (!EXT_RESET && i < 600) begin
      if (i == 10) REQ = 4'b0110;
      if (!BUSY && idle_at < 0) idle_at = i;
      step(1);
      i++;
    end
    chk("cq idle_at", idle_at, 256);
    chk("cq grant_at", i, 257);
    wait_ext_low("cq second");
    chk("cq cause", CAUSE, 4'b0010);
    chk("cq winner", WINNER, 1);
    wait_idle("cq");
    REQ = '0;
    step(1);

    // Masking: dropped edges, pending bits survive.
    REQ_MASK = 4'b0001;
    REQ = 4'b0001;
    step(4);
    chk("mask busy", BUSY, 0);
    chk("mask ext", EXT_RESET, 0);
    REQ_MASK = '0;
    step(4);
    chk("unmask held busy", BUSY, 0);
    REQ = '0;
    step(1);
    REQ = 4'b0001;
    step(2);
    chk("new edge ext", EXT_RESET, 1);
    wait_ext_low("mask");
    chk("mask cause", CAUSE, 4'b0001);
    wait_idle("mask");
    REQ = 4'b0100;
    step(1);
    REQ_MASK = 4'b0100;
    step(1);
    chk("mask late ext", EXT_RESET, 1);
    wait_ext_low("mask late");
    chk("mask late cause", CAUSE, 4'b0100);
    wait_idle("mask late");
    REQ_MASK = '0;
    REQ = '0;
    step(1);
    clr_pulse();

    // Reset in the middle of a pulse.
    REQ = 4'b0100;
    step(2);
    chk("mr ext", EXT_RESET, 1);
    step(5);
    MAIN_RESET_N = 1'b0;
    #1;
    chk("mr ext async", EXT_RESET, 0);
    chk("mr ack", REQ_ACK, 0);
    chk("mr busy", BUSY, 0);
    chk("mr cause", CAUSE, 0);
    chk("mr winner", WINNER, 0);
    chk("mr valid", CAUSE_VALID, 0);
    step(2);
    chk("mr hold ack", REQ_ACK, 0);
    MAIN_RESET_N = 1'b1;
    step(1);
    chk("mr rel ext", EXT_RESET, 0);
    step(1);
    chk("mr held edge ext", EXT_RESET, 1);
    wait_ext_low("mr");
    chk("mr ack after", REQ_ACK, 4'b0100);
    wait_idle("mr");
    REQ = '0;
    step(1);
    clr_pulse();

`ifdef RESET_REQ_TIMEOUT_EN
    PERI_RESET_N = 1'b0;
    REQ = 4'b1000;
    step(2);
    wait_ext_low("tmo");
    step(99);
    chk("tmo early", TIMEOUT_ERR, 0);
    step(1);
    chk("tmo set", TIMEOUT_ERR, 1);
    chk("tmo busy", BUSY, 1);
    step(5);
    chk("tmo sticky", TIMEOUT_ERR, 1);
    clr_pulse();
    chk("tmo clr", TIMEOUT_ERR, 0);
    chk("tmo clr valid", CAUSE_VALID, 0);
    PERI_RESET_N = 1'b1;
    wait_idle("tmo");
    REQ = '0;
    step(1);
`else
    PERI_RESET_N = 1'b0;
    REQ = 4'b1000;
    step(2);
    wait_ext_low("wr");
    step(300);
    chk("wr hold busy", BUSY, 1);
    PERI_RESET_N = 1'b1;
    i = 0;
    while (BUSY && i < 1000) begin
      step(1);
      i++;
    end
    chk("wr rel to idle", i, 257);
    REQ = '0;
    step(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/reset_req_sched.md
Name: reset_req_sched

Overview:
Collects reset requests from multiple in-design sources (watchdog, software register, debug bridge, error monitor) and sequences them into one clean, minimum-width EXT_RESET pulse for the reset controller. After the pulse it waits for the controller's peripheral reset to release, then enforces a cool-down before another pulse can be issued. It records which sources caused the last reset and acknowledges each one. It resets only on MAIN_RESET_N, so it survives the resets it generates.

Parameters:
NUM_REQ, 4, number of request sources; index 0 has the highest priority for the WINNER output.
PULSE_CYCLES, 16, EXT_RESET high time in MAIN_CLK cycles; minimum 1.
COOLDOWN_CYCLES, 256, idle cycles after release before the next grant; 0 is allowed.
TIMEOUT_CYCLES, 65536, WAIT_REL limit; used only when RESET_REQ_TIMEOUT_EN is defined.
CNT_W, 32, width of the internal cycle counter; must hold the largest cycle parameter.

Ports:
MAIN_CLK  in  1  system clock
MAIN_RESET_N  in  1  asynchronous, active-low reset
REQ  in  NUM_REQ  request levels; a rising edge is one request
REQ_MASK  in  NUM_REQ  1 = ignore that source; a masked edge is dropped, not queued
PERI_RESET_N  in  1  release indication from the reset controller, already synchronous to MAIN_CLK
CLR_CAUSE  in  1  single-cycle pulse that clears CAUSE and CAUSE_VALID
EXT_RESET  out  1  reset request pulse to the reset controller
REQ_ACK  out  NUM_REQ  one-cycle acknowledge for each source served
CAUSE  out  NUM_REQ  bitmap of the sources served by the last pulse
WINNER  out  $clog2(NUM_REQ) (minimum 1)  lowest set index of CAUSE
CAUSE_VALID  out  1  CAUSE holds valid data
BUSY  out  1  FSM is not in IDLE
TIMEOUT_ERR  out  1  sticky flag; present only with the optional feature

Behaviour:
- Clock and reset: single clock MAIN_CLK; asynchronous active-low reset MAIN_RESET_N.
- Reset values: FSM=IDLE, EXT_RESET=0, REQ_ACK=0, CAUSE=0, WINNER=0, CAUSE_VALID=0, BUSY=0, pending=0, counter=0, REQ edge-detect register=0 (a REQ held high through reset counts as one edge).
- Edge detect: edge = REQ & ~REQ_q & ~REQ_MASK. Edges are ORed into the pending register in every state except ASSERT.
- IDLE: if pending != 0, go to ASSERT next cycle. On that transition, CAUSE <= pending, WINNER <= lowest set bit of pending, pending <= 0 (any same-cycle edges still land in pending), counter <= 0.
- ASSERT: EXT_RESET=1. Edges in this state are merged into CAUSE, not pending. Leave when counter == PULSE_CYCLES-1, so EXT_RESET is high for exactly PULSE_CYCLES cycles. On exit, REQ_ACK <= CAUSE for one cycle, CAUSE_VALID <= 1, then go to WAIT_REL.
- Grant latency: the edge is registered in cycle N, pending is set, and EXT_RESET rises in cycle N+2.
- WAIT_REL: EXT_RESET=0. Wait for PERI_RESET_N == 1; in the first cycle this is sampled, go to COOLDOWN with counter <= 0. PERI_RESET_N going low and high again inside ASSERT is ignored.
- COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE. With COOLDOWN_CYCLES=0, go straight to IDLE.
- BUSY = (state != IDLE).
- CLR_CAUSE: clears CAUSE, WINNER and CAUSE_VALID in IDLE, WAIT_REL and COOLDOWN. It is ignored in ASSERT, where CAUSE is being built.
- Masking: changing REQ_MASK does not affect bits already pending.
- Counter saturates; it never wraps.
- MAIN_RESET_N asserted mid-sequence: EXT_RESET drops immediately (asynchronously) and all state returns to reset values.
- Encoding: FSM is binary-encoded with 2 bits; unused codes return to IDLE.

Optional Feature:
Macro RESET_REQ_TIMEOUT_EN.
- Defined: in WAIT_REL, if PERI_RESET_N stays low for TIMEOUT_CYCLES cycles, set TIMEOUT_ERR (sticky) and go to COOLDOWN. TIMEOUT_ERR clears only on MAIN_RESET_N or CLR_CAUSE.
- Not defined: WAIT_REL waits indefinitely, the TIMEOUT_ERR port does not exist, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package reset_req_pkg: FSM state encoding (IDLE=0, ASSERT=1, WAIT_REL=2, COOLDOWN=3) and default cycle constants, next to the existing reset count defines.
- One sub-module, reset_req_prio_enc: combinational lowest-set-bit priority encoder used for WINNER. Everything else stays in the top.

Test Plan:
- Single request: NUM_REQ=4, PULSE_CYCLES=16; edge on REQ[2] at cycle 10 -> EXT_RESET high cycles 12..27, REQ_ACK=4'b0100 for one cycle, CAUSE=4'b0100, WINNER=2, CAUSE_VALID=1.
- Simultaneous plus merge: edges on REQ[3] and REQ[1] in the same cycle, then REQ[0] during ASSERT -> one pulse only, CAUSE=4'b1011, WINNER=0, REQ_ACK=4'b1011.
- Queue during cool-down: edge on REQ[1] during COOLDOWN (COOLDOWN_CYCLES=256) -> second pulse starts 1 cycle after COOLDOWN ends, not before.
- Mask: REQ_MASK=4'b0001 with an edge on REQ[0] -> no pulse and BUSY stays 0; unmask with REQ held high -> still no pulse until a new edge.
- Reset mid-ASSERT: drive MAIN_RESET_N low at cycle 5 of the pulse -> EXT_RESET=0 immediately and all outputs at reset values; no REQ_ACK issued.
- Timeout (RESET_REQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100): PERI_RESET_N held low -> TIMEOUT_ERR=1 after 100 WAIT_REL cycles, FSM enters COOLDOWN, CLR_CAUSE clears TIMEOUT_ERR.
